// File: rtl/bank_cmd_pkg.sv
// Shared types and helpers for the bank command responder: command kinds,
// error codes, timer width and the command decoder.
package bank_cmd_pkg;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    PRE,
    RD,
    WR,
    INV
  } cmd_kind_t;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CLOSED = 3'd1;
  localparam logic [2:0] ERR_OPEN   = 3'd2;
  localparam logic [2:0] ERR_INV    = 3'd3;

  // Width of the per-bank tRCD/tRP down-counters.
  localparam int TMR_W = 4;

  // Classify a command from its encoding bits. ACT is tested before PRE and
  // NOP last so that overlapping qualifier patterns resolve deterministically.
  function automatic cmd_kind_t decode_cmd(input logic ras, input logic cas,
                                           input logic we, input logic is_cmd,
                                           input logic is_read,
                                           input logic is_write);
    cmd_kind_t k;
    if (ras && !cas && !we && is_cmd)             k = ACT;
    else if (ras && we && !cas)                   k = PRE;
    else if (cas && !we && !ras && is_read)       k = RD;
    else if (cas && we && !ras && is_write)       k = WR;
    else if (is_cmd && !ras && !cas)              k = NOP;
    else                                          k = INV;
    return k;
  endfunction

endpackage

// File: rtl/bank_cmd_timer.sv
// Per-bank tRCD/tRP down-counter pair. A load takes priority over the
// decrement in the same cycle; both counters saturate at zero.
module bank_cmd_timer
  import bank_cmd_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic load_trcd,
  input  logic load_trp,
  output logic trcd_zero,
  output logic trp_zero
);

  logic [TMR_W-1:0] trcd_cnt;
  logic [TMR_W-1:0] trp_cnt;

  // Load on the bank event, otherwise count down towards zero.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      trcd_cnt <= '0;
      trp_cnt  <= '0;
    end else begin
      if (load_trcd)              trcd_cnt <= TMR_W'(TRCD - 1);
      else if (trcd_cnt != '0)    trcd_cnt <= trcd_cnt - 1'b1;
      if (load_trp)               trp_cnt  <= TMR_W'(TRP - 1);
      else if (trp_cnt != '0)     trp_cnt  <= trp_cnt - 1'b1;
    end
  end

  assign trcd_zero = (trcd_cnt == '0);
  assign trp_zero  = (trp_cnt == '0);

endmodule

// File: rtl/bank_cmd_responder.sv
// DRAM-side responder for the bank-machine command stream. Tracks open rows
// per bank, stalls ACT/RD/WR until tRP/tRCD have elapsed, returns read-data
// strobes CL cycles after each read and latches the first protocol error.
// Optional command counters are built when BANK_CMD_RESPONDER_COUNTERS_EN is
// defined; otherwise cnt_act/cnt_rd/cnt_wr read as zero.
module bank_cmd_responder
  import bank_cmd_pkg::*;
#(
  parameter int NBANKS = 8,
  parameter int ROW_W  = 14,
  parameter int TRCD   = 3,
  parameter int TRP    = 3,
  parameter int CL     = 4,
  localparam int BA_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_first,
  input  logic             cmd_last,
  input  logic [ROW_W-1:0] cmd_payload_a,
  input  logic [BA_W-1:0]  cmd_payload_ba,
  input  logic             cmd_payload_cas,
  input  logic             cmd_payload_ras,
  input  logic             cmd_payload_we,
  input  logic             cmd_payload_is_cmd,
  input  logic             cmd_payload_is_read,
  input  logic             cmd_payload_is_write,
  output logic             rdata_valid,
  output logic [ROW_W-1:0] rdata_col,
  output logic             wdata_ready,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [15:0]      cnt_act,
  output logic [15:0]      cnt_rd,
  output logic [15:0]      cnt_wr
);

  cmd_kind_t              kind;
  logic [BA_W-1:0]        ba;
  logic                   ready_kind;
  logic                   accept;
  logic                   legal_act;
  logic                   legal_rd;
  logic                   legal_wr;
  logic                   close_now;
  logic [2:0]             err_hit_code;
  logic [NBANKS-1:0]      bank_open;
  logic [NBANKS-1:0][ROW_W-1:0] bank_row;
  logic [NBANKS-1:0]      trcd_zero;
  logic [NBANKS-1:0]      trp_zero;
  logic [CL-1:0]          rd_vld_p;
  logic [CL-1:0][ROW_W-1:0] rd_col_p;
  logic                   unused_ok;

  assign kind = decode_cmd(cmd_payload_ras, cmd_payload_cas, cmd_payload_we,
                           cmd_payload_is_cmd, cmd_payload_is_read,
                           cmd_payload_is_write);
  assign ba   = cmd_payload_ba;

  // Stall ACT until tRP has expired and RD/WR until tRCD has expired.
  always_comb begin
    ready_kind = 1'b1;
    case (kind)
      ACT:     ready_kind = trp_zero[ba];
      RD, WR:  ready_kind = trcd_zero[ba];
      default: ready_kind = 1'b1;
    endcase
  end

  assign cmd_ready   = sys_rst && ready_kind;
  assign accept      = cmd_valid && cmd_ready;
  assign wdata_ready = accept && (kind == WR);

  // Illegal commands are still accepted but must not touch bank state.
  assign legal_act = accept && (kind == ACT) && !bank_open[ba];
  assign legal_rd  = accept && (kind == RD)  &&  bank_open[ba];
  assign legal_wr  = accept && (kind == WR)  &&  bank_open[ba];
  assign close_now = (accept && (kind == PRE)) ||
                     ((legal_rd || legal_wr) && cmd_payload_a[10]);

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic sel;
    assign sel = (ba == BA_W'(b));
    bank_cmd_timer #(
      .TRCD (TRCD),
      .TRP  (TRP)
    ) u_timer (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .load_trcd (sel && legal_act),
      .load_trp  (sel && close_now),
      .trcd_zero (trcd_zero[b]),
      .trp_zero  (trp_zero[b])
    );
  end

  // Open/closed flag per bank; PRE and auto-precharge both close.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst)        bank_open     <= '0;
    else if (legal_act)  bank_open[ba] <= 1'b1;
    else if (close_now)  bank_open[ba] <= 1'b0;
  end

  // Row captured on each legal ACT.
  always_ff @(posedge sys_clk) begin
    if (legal_act) bank_row[ba] <= cmd_payload_a;
  end

  // Classify the error, if any, carried by this cycle's accepted command.
  always_comb begin
    err_hit_code = ERR_NONE;
    if (accept) begin
      case (kind)
        ACT:     if (bank_open[ba])  err_hit_code = ERR_OPEN;
        RD, WR:  if (!bank_open[ba]) err_hit_code = ERR_CLOSED;
        INV:     err_hit_code = ERR_INV;
        default: err_hit_code = ERR_NONE;
      endcase
    end
  end

  // Sticky error flag; the code of the first error is kept until reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if ((err_hit_code != ERR_NONE) && !err) begin
      err      <= 1'b1;
      err_code <= err_hit_code;
    end
  end

  // Read return pipeline: stage 0 captures the accepted read, stage CL-1 drives the outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      rd_vld_p <= '0;
      rd_col_p <= '0;
    end else begin
      rd_vld_p[0] <= legal_rd;
      rd_col_p[0] <= legal_rd ? cmd_payload_a : '0;
      for (int i = 1; i < CL; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        rd_col_p[i] <= rd_col_p[i-1];
      end
    end
  end

  assign rdata_valid = rd_vld_p[CL-1];
  assign rdata_col   = rd_col_p[CL-1];

`ifdef BANK_CMD_RESPONDER_COUNTERS_EN
  // Wrapping counts of legal accepted ACT/RD/WR commands.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      cnt_act <= '0;
      cnt_rd  <= '0;
      cnt_wr  <= '0;
    end else begin
      if (legal_act) cnt_act <= cnt_act + 16'd1;
      if (legal_rd)  cnt_rd  <= cnt_rd + 16'd1;
      if (legal_wr)  cnt_wr  <= cnt_wr + 16'd1;
    end
  end
`else
  assign cnt_act = '0;
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
`endif

  // Stream framing bits and the stored rows have no consumer in this model.
  assign unused_ok = ^{cmd_first, cmd_last, bank_row};

endmodule
